// File: rtl/logic_unit_pkg.sv
// Shared encodings for the iterative logic unit.
// This file holds the operation codes and the FSM state type.
package logic_unit_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// One chunk of the bitwise logic function.
// The block is purely combinational. Each output bit depends only on the
// operand bits at the same index.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [1:0]       op,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic [CHUNK-1:0] y
);

   // Select the bitwise function for this chunk.
   always_comb begin
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = ~(a | b);
      endcase
   end

endmodule

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit with valid/ready handshakes.
// The unit latches the operands and evaluates CHUNK bits per cycle,
// starting with the LSB chunk. It presents the full result once the last
// chunk has been written.
module logic_unit_iter
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("logic_unit_iter: WIDTH must be a multiple of CHUNK");
   end

   state_t           state;
   logic [CW-1:0]    count;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_next;
   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CHUNK-1:0] y_c;
   int               base;

   // Accept only while idle; busy and done both hold the port closed.
   assign in_ready = (state == S_IDLE);

   // Pick the chunk addressed by the counter and merge the slice result into it.
   always_comb begin
      base     = int'(count) * CHUNK;
      a_c      = a_q[base +: CHUNK];
      b_c      = b_q[base +: CHUNK];
      res_next = res_q;
      res_next[base +: CHUNK] = y_c;
   end

   logic_slice #(.CHUNK(CHUNK)) u_slice (
      .op (op_q),
      .a  (a_c),
      .b  (b_c),
      .y  (y_c)
   );

   // Control FSM, chunk counter, operand latches and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         out       <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  a_q   <= inp1;
                  b_q   <= inp2;
                  res_q <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               res_q <= res_next;
               if (count == LAST) begin
                  // out is loaded only here, so it keeps the previous result while idle or busy.
                  out       <= res_next;
                  zero      <= (res_next == '0);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_iter.sv
// Randomised and directed bench for logic_unit_iter.
// Two instances are used: one processes 8 bits per chunk and the other processes the full 32-bit width at once.
module tb_logic_unit_iter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        iv, ir, ov, ordy, z, bz;
   logic [1:0]  opx;
   logic [31:0] i1, i2, o;

   logic        b_iv, b_ir, b_ov, b_ordy, b_z, b_bz;
   logic [1:0]  b_op;
   logic [31:0] b_i1, b_i2, b_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_unit_iter #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .op(opx),
      .inp1(i1), .inp2(i2), .out_valid(ov), .out_ready(ordy), .out(o),
      .zero(z), .busy(bz)
   );

   logic_unit_iter #(.WIDTH(32), .CHUNK(32)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .op(b_op),
      .inp1(b_i1), .inp2(b_i2), .out_valid(b_ov), .out_ready(b_ordy), .out(b_o),
      .zero(b_z), .busy(b_bz)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bit-by-bit truth table of the four operations.
   function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         case (f)
            2'd0:    r[i] = a[i] && b[i];
            2'd1:    r[i] = a[i] || b[i];
            2'd2:    r[i] = a[i] != b[i];
            default: r[i] = !(a[i] || b[i]);
         endcase
      end
      return r;
   endfunction

   task automatic run_a(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit scr, input int hold);
      int n;
      n = 0;
      while (!ir && n < 20) begin @(posedge clk); #1; n++; end
      chk("a_ready_idle", 64'(ir), 64'(1));
      opx = f; i1 = a; i2 = b; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      n = 0;
      while (!ov && n < 20) begin
         if (scr) begin
            opx = 2'($urandom); i1 = $urandom; i2 = $urandom; iv = 1'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      iv = 1'b0;
      chk("a_latency", 64'(n), 64'(4));
      chk("a_out", 64'(o), 64'(exp));
      chk("a_zero", 64'(z), 64'(exp == 32'h0));
      chk("a_busy_done", 64'(bz), 64'(1));
      chk("a_inrdy_done", 64'(ir), 64'(0));
      for (int k = 0; k < hold; k++) begin
         iv = (k == 1); opx = 2'($urandom); i1 = $urandom; i2 = $urandom;
         @(posedge clk); #1;
         chk("a_hold_out", 64'(o), 64'(exp));
         chk("a_hold_zero", 64'(z), 64'(exp == 32'h0));
         chk("a_hold_vld", 64'(ov), 64'(1));
         chk("a_hold_rdy", 64'(ir), 64'(0));
      end
      iv = 1'b0; ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      chk("a_ovld_drop", 64'(ov), 64'(0));
      chk("a_inrdy_back", 64'(ir), 64'(1));
      chk("a_busy_drop", 64'(bz), 64'(0));
      chk("a_out_kept", 64'(o), 64'(exp));
   endtask

   task automatic run_b(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      int n;
      n = 0;
      while (!b_ir && n < 20) begin @(posedge clk); #1; n++; end
      chk("b_ready_idle", 64'(b_ir), 64'(1));
      b_op = f; b_i1 = a; b_i2 = b; b_iv = 1'b1;
      @(posedge clk); #1;
      b_iv = 1'b0;
      n = 0;
      while (!b_ov && n < 20) begin @(posedge clk); #1; n++; end
      chk("b_latency", 64'(n), 64'(1));
      chk("b_out", 64'(b_o), 64'(exp));
      chk("b_zero", 64'(b_z), 64'(exp == 32'h0));
      @(posedge clk); #1;
      chk("b_ovld_drop", 64'(b_ov), 64'(0));
      chk("b_inrdy_back", 64'(b_ir), 64'(1));
   endtask

   initial begin
      logic [1:0]  rf;
      logic [31:0] ra, rb;
      bit          spurious;

      rst_n = 1'b0;
      iv = 1'b0; opx = 2'b00; i1 = '0; i2 = '0; ordy = 1'b0;
      b_iv = 1'b0; b_op = 2'b00; b_i1 = '0; b_i2 = '0; b_ordy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 64'(o), 64'(0));
      chk("rst_zero", 64'(z), 64'(0));
      chk("rst_ovld", 64'(ov), 64'(0));
      chk("rst_busy", 64'(bz), 64'(0));
      rst_n = 1'b1;
      #1;
      chk("rst_inrdy", 64'(ir), 64'(1));
      @(posedge clk); #1;

      // Directed operations on the chunked instance.
      run_a(2'b00, 32'h0000A5A5, 32'h00005A5A, 32'h00000000, 1'b0, 0);
      run_a(2'b01, 32'h0000A5A5, 32'h00005A5A, 32'h0000FFFF, 1'b0, 0);
      run_a(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 0);
      run_a(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 5);
      run_a(2'b10, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b1, 0);

      // The reset lands in the middle of a busy operation, when count is 2.
      opx = 2'b00; i1 = 32'h0F0F0F0F; i2 = 32'hFFFFFFFF; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("busy_out_prev", 64'(o), 64'(32'h1D3B5977));
      chk("busy_flag", 64'(bz), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 64'(o), 64'(0));
      chk("mid_rst_ovld", 64'(ov), 64'(0));
      chk("mid_rst_busy", 64'(bz), 64'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_inrdy", 64'(ir), 64'(1));
      spurious = 1'b0;
      repeat (8) begin
         if (ov) spurious = 1'b1;
         @(posedge clk); #1;
      end
      chk("post_rst_no_vld", 64'(spurious), 64'(0));

      // Random operations, some with input churn during busy and some with backpressure.
      for (int t = 0; t < 25; t++) begin
         rf = 2'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
         run_a(rf, ra, rb, model(rf, ra, rb), 1'($urandom), int'($urandom_range(0, 3)));
      end

      // Single-chunk instance: one-edge latency, with out_ready held high throughout.
      run_b(2'b00, 32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A50000);
      for (int t = 0; t < 6; t++) begin
         rf = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         run_b(rf, ra, rb, model(rf, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
